// File: rtl/sa3_tile_ctrl_pkg.sv
// sa3_tile_ctrl_pkg: shared FSM encoding, geometry, address map and storage types for the tile controller
package sa3_tile_ctrl_pkg;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2, S_WAIT = 3'd3, S_STORE = 3'd4, S_FIN = 3'd5;
  localparam int IMG_DIM = 6, KER_DIM = 3, RES_DIM = 4, WIN_DIM = 4;
  localparam int IMG_N = IMG_DIM * IMG_DIM, KER_N = KER_DIM * KER_DIM, RES_N = RES_DIM * RES_DIM;
  localparam logic [5:0] KERNEL_BASE = 6'd36;
  localparam logic [5:0] KERNEL_END = KERNEL_BASE + 6'(KER_N);
  typedef logic [IMG_N-1:0][7:0] img_t;
  typedef logic [KER_N-1:0][7:0] ker_t;
  typedef logic [RES_N-1:0][7:0] res_t;
  typedef logic [WIN_DIM*WIN_DIM-1:0][7:0] win_t;
  function automatic logic [5:0] tile_base(input logic [1:0] tile);
    return (tile[1] ? 6'(2 * IMG_DIM) : 6'd0) + (tile[0] ? 6'd2 : 6'd0);
  endfunction
endpackage

// File: rtl/sa3_window_mux.sv
// sa3_window_mux: selects the 4x4 image window of the current stride-2 tile
module sa3_window_mux
  import sa3_tile_ctrl_pkg::*;
(
  input  logic [1:0] tile,
  input  img_t       img,
  output win_t       win
);
  logic [5:0] base;
  assign base = tile_base(tile);
  for (genvar i = 0; i < WIN_DIM; i++) begin : g_r
    for (genvar j = 0; j < WIN_DIM; j++) begin : g_c
      assign win[i*WIN_DIM+j] = img[base + 6'(i * IMG_DIM + j)];
    end
  end
endmodule

// File: rtl/sa3_tile_ctrl.sv
// sa3_tile_ctrl: sequences four 3x3 stride-2 convolution tiles of a 6x6 image through an external array
module sa3_tile_ctrl
  import sa3_tile_ctrl_pkg::*;
#(
  parameter int SETUP_CYC  = 3,
  parameter int ACTIVE_CYC = 17,
  parameter int TIMEOUT    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       sa_rst,
  output logic       active_sa3,
  output logic [7:0] a11, a12, a13, a14, a21, a22, a23, a24,
  output logic [7:0] a31, a32, a33, a34, a41, a42, a43, a44,
  output logic [7:0] b11, b12, b13, b21, b22, b23, b31, b32, b33,
  input  logic       done_sa3,
  input  logic [7:0] c11, c12, c21, c22
);
  logic [2:0] state_q, state_d;
  logic [1:0] tile_q, tile_d;
  logic [15:0] cnt_q, cnt_d;
  logic err_q, err_d;
  img_t img_q, img_d;
  ker_t ker_q, ker_d;
  res_t res_q, res_d;
  logic [3:0][7:0] cap_q, cap_d;
  logic [3:0] rb;
  win_t win;
  sa3_window_mux u_win (.tile(tile_q), .img(img_q), .win(win));
  assign {a44, a43, a42, a41, a34, a33, a32, a31, a24, a23, a22, a21, a14, a13, a12, a11} = win;
  assign {b33, b32, b31, b23, b22, b21, b13, b12, b11} = ker_q;
  assign busy = state_q != S_IDLE && state_q != S_FIN;
  assign done = state_q == S_FIN;
  assign err = err_q;
  assign active_sa3 = state_q == S_RUN;
  assign sa_rst = !rst || (state_q == S_LOAD && cnt_q == 16'd0);
  assign rd_data = res_q[rd_addr];
  assign rb = {tile_q[1], 1'b0, tile_q[0], 1'b0};
  always_comb begin
    state_d = state_q;
    tile_d = tile_q;
    cnt_d = cnt_q + 16'd1;
    err_d = err_q;
    img_d = img_q;
    ker_d = ker_q;
    res_d = res_q;
    cap_d = cap_q;
    if (!busy && wr_en && wr_addr < KERNEL_BASE) img_d[wr_addr] = wr_data;
    if (!busy && wr_en && wr_addr >= KERNEL_BASE && wr_addr < KERNEL_END) ker_d[4'(wr_addr - KERNEL_BASE)] = wr_data;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        tile_d = 2'd0;
        err_d = 1'b0;
        cnt_d = 16'd0;
      end
      S_LOAD: if (cnt_q == 16'(SETUP_CYC - 1)) begin
        state_d = S_RUN;
        cnt_d = 16'd0;
      end
      S_RUN: if (cnt_q == 16'(ACTIVE_CYC - 1)) begin
        state_d = S_WAIT;
        cnt_d = 16'd0;
      end
      S_WAIT: if (done_sa3) begin
        state_d = S_STORE;
        cap_d = {c22, c21, c12, c11};
      end else if (cnt_q == 16'(TIMEOUT - 1)) begin
        state_d = S_FIN;
        err_d = 1'b1;
      end
      S_STORE: begin
        res_d[rb] = cap_q[0];
        res_d[rb + 4'd1] = cap_q[1];
        res_d[rb + 4'd4] = cap_q[2];
        res_d[rb + 4'd5] = cap_q[3];
        tile_d = tile_q + 2'd1;
        cnt_d = 16'd0;
        state_d = tile_q == 2'd3 ? S_FIN : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tile_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      img_q <= '0;
      ker_q <= '0;
      res_q <= '0;
      cap_q <= '0;
    end else begin
      state_q <= state_d;
      tile_q <= tile_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      img_q <= img_d;
      ker_q <= ker_d;
      res_q <= res_d;
      cap_q <= cap_d;
    end
  end
endmodule

// File: doc/sa3_tile_ctrl.md
SA3_TILE_CTRL -- requirements
Module: sa3_tile_ctrl

Interface
REQ-001 Parameter SETUP_CYC, default 3: cycles the window/kernel are held stable before active_sa3 rises.
REQ-002 Parameter ACTIVE_CYC, default 17: cycles active_sa3 is held high per tile.
REQ-003 Parameter TIMEOUT, default 32: max cycles waiting for done_sa3 after active_sa3 falls.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request to convolve the stored image; sampled in IDLE only.
REQ-007 busy  output  1  high from the cycle after start is accepted until done.
REQ-008 done  output  1  one-cycle pulse at job end.
REQ-009 err  output  1  sticky timeout flag; cleared by the next accepted start.
REQ-010 wr_en / wr_addr / wr_data  input  1 / 6 / 8  load port; addr 0..35 image row-major (row*6+col), 36..44 kernel row-major, 45..63 ignored.
REQ-011 rd_addr / rd_data  input 4 / output 8  combinational read of 16-entry result map, row-major 4x4.
REQ-012 sa_rst  output  1  active-high clear to the array.
REQ-013 active_sa3  output  1  array run enable.
REQ-014 a11..a44  output  8 each  4x4 window to the array.
REQ-015 b11..b33  output  8 each  3x3 kernel to the array.
REQ-016 done_sa3  input  1  array completion.
REQ-017 c11, c12, c21, c22  input  8 each  array 2x2 result.

Function
REQ-018 Image 6x6, kernel 3x3, stride 2, four tiles (tr,tc) in order (0,0),(0,1),(1,0),(1,1).
REQ-019 Window for tile (tr,tc): a_ij = img[2tr+i-1][2tc+j-1], i,j in 1..4; b_ij = kernel[i-1][j-1] continuously.
REQ-020 Result mapping: c11->res[2tr][2tc], c12->res[2tr][2tc+1], c21->res[2tr+1][2tc], c22->res[2tr+1][2tc+1]; res index = row*4+col; 8-bit, no widening.
REQ-021 FSM states IDLE, LOAD, RUN, WAIT, STORE, FIN.
REQ-022 IDLE: start=1 -> LOAD, tile=0, err cleared.
REQ-023 LOAD: sa_rst=1 first cycle only; window valid from first LOAD cycle; after SETUP_CYC cycles -> RUN.
REQ-024 RUN: active_sa3=1 exactly ACTIVE_CYC cycles, then -> WAIT with active_sa3=0.
REQ-025 WAIT: done_sa3=1 -> STORE, capturing c11..c22 that cycle; counter reaching TIMEOUT -> err=1, FIN, results for remaining tiles not written.
REQ-026 STORE: one cycle, writes 4 results; tile<3 -> tile+1, LOAD; tile=3 -> FIN.
REQ-027 FIN: done=1 one cycle, busy=0 same cycle, -> IDLE.
REQ-028 done_sa3 outside WAIT is ignored.
REQ-029 wr_en while busy is ignored; start while busy is ignored.
REQ-030 Simultaneous start and wr_en in IDLE: write commits, start accepted, job uses new value.
REQ-031 rd_data reflects result map at all times, including mid-job partial updates.

Reset
REQ-032 rst=0 at a rising edge: state IDLE, tile/counters 0, busy/done/err/active_sa3=0, sa_rst=1 while rst=0, image/kernel/result storage cleared to 0, window outputs 0.
REQ-033 Reset mid-job aborts immediately; no done pulse.

Structure
REQ-034 Shared package holds FSM state encoding, image/kernel/result dimensions and address base constants (KERNEL_BASE=36).
REQ-035 One sub-module sa3_window_mux: combinational tile index plus image storage -> a11..a44.

Verification
REQ-036 Load img[r][c]=r*6+c+1, kernel 1..9; stub array returns c11=a11,c12=a12,c21=a21,c22=a22, done_sa3 one cycle after active_sa3 falls -> res[0]=1,res[1]=2,res[2]=3,res[3]=4,res[4]=7,res[8]=13,res[15]=22; done once.
REQ-037 Same run: per tile sa_rst high 1 cycle, active_sa3 high exactly 17 cycles starting 3 cycles after LOAD entry; job length 4x(3+17+1+1)+1 cycles from start.
REQ-038 Stub never asserts done_sa3 -> err=1 and done pulse 32 cycles after first active_sa3 fall; result map unchanged.
REQ-039 rst low during second tile RUN -> next cycle busy=0, active_sa3=0, rd_data=0 for all addresses, no done.
REQ-040 wr_en to addr 5 with 0xAA while busy, and start pulse while busy -> img[0][5] unchanged, single done only.
